regfile_scoreboard: RTL and testbench

Parametrised multi-register file with per-register write scoreboard for the pipelined MIPS core. Provides two combinational read ports, one synchronous write port, optional same-cycle write-to-read bypass and a hardwired zero register. Adds a reservation scoreboard: issue reserves a destination register, writeback releases it, so decode can stall on pending results. Sits between decode (read and reserve) and writeback (write and release).

---
 rtl/regfile_scoreboard_if.sv | 31 +++
 rtl/regfile_scoreboard.sv | 77 +++++++
 tb/tb_regfile_scoreboard.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback bus of the register file: two read ports, a write port,
// and the reservation and flush controls of the pending-result scoreboard.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_ack;
  logic              flush;
  logic              any_busy;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_ack, any_busy
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, rsv_ack, any_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass and a per-register pending-write counter for stalls.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int CNT_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_cnt [DEPTH];

  logic [DEPTH-1:0]  w_inc;
  logic [DEPTH-1:0]  w_dec;
  logic [DEPTH-1:0]  w_wr;
  logic [DEPTH-1:0]  w_nonzero;

  logic [CNT_W-1:0]  w_rsv_cnt;
  logic              w_rsv_zero;
  logic              w_rsv_release;
  logic              w_ack;

  // A full counter still accepts when the same edge retires one of its writes.
  assign w_rsv_cnt     = r_cnt[bus.rsv_addr];
  assign w_rsv_zero    = (ZERO_REG != 0) && (bus.rsv_addr == '0);
  assign w_rsv_release = bus.wr_en && (bus.wr_addr == bus.rsv_addr) && (w_rsv_cnt != '0);
  assign w_ack         = bus.rsv_en && !w_rsv_zero && ((w_rsv_cnt != CNT_MAX) || w_rsv_release);
  assign bus.rsv_ack   = w_ack;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    assign w_inc[gi]     = w_ack && (bus.rsv_addr == ADDR_W'(gi));
    assign w_dec[gi]     = bus.wr_en && (bus.wr_addr == ADDR_W'(gi)) && (r_cnt[gi] != '0);
    assign w_wr[gi]      = bus.wr_en && (bus.wr_addr == ADDR_W'(gi)) && !((ZERO_REG != 0) && (gi == 0));
    assign w_nonzero[gi] = (r_cnt[gi] != '0);
  end

  assign bus.any_busy = |w_nonzero;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        r_mem[i] <= '0;
        r_cnt[i] <= '0;
      end else begin
        if (w_wr[i]) r_mem[i] <= bus.wr_data;
        if (bus.flush)                 r_cnt[i] <= '0;
        else if (w_inc[i] && !w_dec[i]) r_cnt[i] <= r_cnt[i] + CNT_ONE;
        else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - CNT_ONE;
      end
    end
  end

  logic [CNT_W-1:0] w_cnt1, w_cnt2;
  logic             w_fwd1, w_fwd2;
  logic             w_zero1, w_zero2;

  assign w_cnt1  = r_cnt[bus.rd_addr1];
  assign w_cnt2  = r_cnt[bus.rd_addr2];
  assign w_fwd1  = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr1);
  assign w_fwd2  = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == bus.rd_addr2);
  assign w_zero1 = (ZERO_REG != 0) && (bus.rd_addr1 == '0);
  assign w_zero2 = (ZERO_REG != 0) && (bus.rd_addr2 == '0);

  // A forwarded final writeback already satisfies the reader, so it is not busy.
  assign bus.rd_data1 = w_zero1 ? '0 : (w_fwd1 ? bus.wr_data : r_mem[bus.rd_addr1]);
  assign bus.rd_data2 = w_zero2 ? '0 : (w_fwd2 ? bus.wr_data : r_mem[bus.rd_addr2]);
  assign bus.rd_busy1 = !w_zero1 && (w_cnt1 != '0) && !(w_fwd1 && (w_cnt1 == CNT_ONE));
  assign bus.rd_busy2 = !w_zero2 && (w_cnt2 != '0) && !(w_fwd2 && (w_cnt2 == CNT_ONE));
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios followed by random traffic,
// every output compared each cycle against an array/counter reference model.
module tb_regfile_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;
  localparam int MAXCNT = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf_if ();

  regfile_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .BYPASS(1), .CNT_W(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rf_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_mem [NREG];
  int          m_cnt [NREG];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (rf_if.wr_en && rf_if.wr_addr == a) return rf_if.wr_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0 || m_cnt[a] == 0) return 1'b0;
    if (rf_if.wr_en && rf_if.wr_addr == a && m_cnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_ack();
    if (!rf_if.rsv_en || rf_if.rsv_addr == 0) return 1'b0;
    if (m_cnt[rf_if.rsv_addr] < MAXCNT) return 1'b1;
    return rf_if.wr_en && (rf_if.wr_addr == rf_if.rsv_addr);
  endfunction

  function automatic logic exp_any();
    for (int i = 0; i < NREG; i++) if (m_cnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear(input logic data_too);
    for (int i = 0; i < NREG; i++) begin
      m_cnt[i] = 0;
      if (data_too) m_mem[i] = 32'h0;
    end
  endtask

  // Compare all outputs mid-cycle, then advance one edge and update the model.
  task automatic cycle(input string tag);
    logic ack, dec;
    #3;
    check_eq({tag, ".rd1"},   rf_if.rd_data1, exp_data(rf_if.rd_addr1));
    check_eq({tag, ".rd2"},   rf_if.rd_data2, exp_data(rf_if.rd_addr2));
    check_eq({tag, ".busy1"}, {31'b0, rf_if.rd_busy1}, {31'b0, exp_busy(rf_if.rd_addr1)});
    check_eq({tag, ".busy2"}, {31'b0, rf_if.rd_busy2}, {31'b0, exp_busy(rf_if.rd_addr2)});
    check_eq({tag, ".ack"},   {31'b0, rf_if.rsv_ack},  {31'b0, exp_ack()});
    check_eq({tag, ".any"},   {31'b0, rf_if.any_busy}, {31'b0, exp_any()});
    @(posedge clk);
    if (reset) begin
      model_clear(1'b1);
    end else begin
      ack = exp_ack();
      dec = rf_if.wr_en && (m_cnt[rf_if.wr_addr] > 0);
      if (rf_if.wr_en && rf_if.wr_addr != 0) m_mem[rf_if.wr_addr] = rf_if.wr_data;
      if (rf_if.flush) model_clear(1'b0);
      else begin
        if (ack) m_cnt[rf_if.rsv_addr]++;
        if (dec) m_cnt[rf_if.wr_addr]--;
      end
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b0;
    rf_if.wr_en = 1'b0;
    rf_if.rsv_en = 1'b0;
    rf_if.flush = 1'b0;
  endtask

  task automatic do_wr(input logic [4:0] a, input logic [31:0] d);
    rf_if.wr_en = 1'b1;
    rf_if.wr_addr = a;
    rf_if.wr_data = d;
  endtask

  task automatic do_rsv(input logic [4:0] a);
    rf_if.rsv_en = 1'b1;
    rf_if.rsv_addr = a;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    rf_if.rd_addr1 = a1;
    rf_if.rd_addr2 = a2;
  endtask

  initial begin
    idle();
    rf_if.wr_addr = '0; rf_if.wr_data = '0; rf_if.rsv_addr = '0;
    rd(5'd0, 5'd0);
    reset = 1'b1;
    @(posedge clk);
    model_clear(1'b1);
    #1;
    idle();

    // Reset sweep of every address on both ports
    for (int a = 0; a < NREG; a++) begin
      rd(5'(a), 5'(NREG - 1 - a));
      cycle("sweep");
    end

    // Bypass write then stored value; writes to r0 ignored
    do_wr(5'd5, 32'hDEADBEEF); rd(5'd5, 5'd0);
    #2 check_eq("t2.bypass", rf_if.rd_data1, 32'hDEADBEEF);
    cycle("t2a");
    idle(); do_wr(5'd0, 32'h1234_5678); rd(5'd5, 5'd0);
    #2 check_eq("t2.stored", rf_if.rd_data1, 32'hDEADBEEF);
    check_eq("t2.r0_fwd", rf_if.rd_data2, 32'h0);
    cycle("t2b");
    idle();
    #2 check_eq("t2.r0", rf_if.rd_data2, 32'h0);
    cycle("t2c");

    // Saturate r7, then drain with three writebacks
    rd(5'd7, 5'd0);
    for (int k = 0; k < 3; k++) begin
      do_rsv(5'd7);
      #2 check_eq("t3.ack", {31'b0, rf_if.rsv_ack}, 32'd1);
      cycle("t3r");
    end
    do_rsv(5'd7);
    #2 check_eq("t3.sat", {31'b0, rf_if.rsv_ack}, 32'd0);
    cycle("t3s");
    idle();
    for (int k = 0; k < 3; k++) begin
      do_wr(5'd7, 32'h70 + 32'(k));
      #2 check_eq("t3.busy", {31'b0, rf_if.rd_busy1}, (k == 2) ? 32'd0 : 32'd1);
      cycle("t3w");
    end
    idle();
    #2 check_eq("t3.any", {31'b0, rf_if.any_busy}, 32'd0);
    cycle("t3e");

    // Reserve and release r9 in the same cycle; writeback to unreserved r3
    do_rsv(5'd9); rd(5'd9, 5'd3);
    cycle("t4a");
    do_rsv(5'd9); do_wr(5'd9, 32'h99);
    #2 check_eq("t4.ack", {31'b0, rf_if.rsv_ack}, 32'd1);
    cycle("t4b");
    idle(); do_wr(5'd3, 32'h33);
    #2 check_eq("t4.busy9", {31'b0, rf_if.rd_busy1}, 32'd1);
    cycle("t4c");
    idle(); do_wr(5'd9, 32'h9A);
    cycle("t4d");
    idle();
    #2 check_eq("t4.r3", rf_if.rd_data2, 32'h33);
    check_eq("t4.busy3", {31'b0, rf_if.rd_busy2}, 32'd0);
    cycle("t4e");

    // Flush with a concurrent data write
    do_rsv(5'd4); rd(5'd4, 5'd6);
    cycle("t5a");
    do_rsv(5'd6);
    cycle("t5b");
    idle(); rf_if.flush = 1'b1; do_wr(5'd4, 32'h12);
    cycle("t5c");
    idle();
    #2 check_eq("t5.busy4", {31'b0, rf_if.rd_busy1}, 32'd0);
    check_eq("t5.busy6", {31'b0, rf_if.rd_busy2}, 32'd0);
    check_eq("t5.r4", rf_if.rd_data1, 32'h12);
    cycle("t5d");

    // Reset overrides a concurrent write
    do_rsv(5'd2); rd(5'd2, 5'd2);
    cycle("t6a");
    idle(); do_wr(5'd2, 32'h55);
    cycle("t6b");
    idle(); do_wr(5'd2, 32'hAA); reset = 1'b1;
    cycle("t6c");
    idle();
    #2 check_eq("t6.r2", rf_if.rd_data1, 32'h0);
    check_eq("t6.busy", {31'b0, rf_if.rd_busy1}, 32'd0);
    cycle("t6d");

    // Random traffic concentrated on a few registers to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      rf_if.flush = ($urandom_range(0, 47) == 0);
      rf_if.wr_en = $urandom_range(0, 2) == 0;
      rf_if.rsv_en = $urandom_range(0, 1) == 1;
      rf_if.wr_addr  = 5'($urandom_range(0, 7));
      rf_if.rsv_addr = 5'($urandom_range(0, 7));
      rf_if.wr_data  = $urandom;
      rf_if.rd_addr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rf_if.rd_addr2 = ($urandom_range(0, 3) == 0) ? rf_if.wr_addr : 5'($urandom_range(0, 7));
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
